snn_layer_engine: RTL and testbench
===================================

Name: snn_layer_engine

Overview:
- Parametrised, reusable fully-connected layer sequencer for the SNN datapath.
- Computes N_OUT neurons, each as a MAC over N_IN inputs.
- Each neuron result is scaled, saturated, passed through the external activation LUT and written to an external output RAM.
- Optional argmax mode tracks the winning neuron, so the same block serves as a hidden layer (argmax_en=0) or the output/classification layer (argmax_en=1).
- All memories are external synchronous-read RAM/ROM instances with 1-cycle read latency.

Parameters:
- N_IN, 784, inputs per neuron (>=2)
- N_OUT, 32, neurons in the layer (>=1)
- DW, 8, data width of input, weight, LUT and output words
- ACC_W, 26, signed accumulator width
- SHIFT, 7, arithmetic right shift applied to the accumulator before LUT addressing
- LUT_AW, 11, activation LUT address width

Ports:
- clk, in, 1, clock; all state updates on rising edge
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, begin layer; sampled only in IDLE
- abort, in, 1, cancel layer; returns to IDLE
- argmax_en, in, 1, argmax mode; latched when start is accepted
- in_addr, out, clog2(N_IN), input RAM address
- in_q, in, DW, input word, unsigned, valid 1 cycle after in_addr
- w_addr, out, clog2(N_IN*N_OUT), weight ROM address
- w_q, in, DW, weight word, signed two's complement, valid 1 cycle after w_addr
- lut_addr, out, LUT_AW, activation LUT address
- lut_q, in, DW, LUT output, valid 1 cycle after lut_addr
- out_addr, out, clog2(N_OUT), output RAM write address
- out_data, out, DW, output RAM write data (= lut_q)
- out_we, out, 1, output RAM write strobe
- busy, out, 1, high in every non-IDLE state
- done, out, 1, single-cycle completion pulse
- digit, out, clog2(N_OUT), argmax index
- digit_val, out, DW, argmax value

Behaviour:
- Reset values: all addresses 0, out_data 0, out_we 0, busy 0, done 0, digit 0, digit_val 0, accumulator 0, state IDLE.
- States: IDLE, MAC, DRAIN, LUT, WRITE, DONE.
- IDLE:
  - start=1 and abort=0 -> MAC.
  - On entry to MAC: neuron=0, i=0, w_addr=0, accumulator cleared, argmax_en latched.
  - If argmax_en=1, digit and digit_val are cleared to 0.
- MAC (N_IN cycles):
  - Drive in_addr=i and w_addr=running counter; the counter increments by 1 every MAC cycle and is never reset between neurons, so w_addr = neuron*N_IN+i with no multiplier.
  - From the second MAC cycle on: acc += signed({1'b0,in_q}) * signed(w_q), sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; no overflow detection.
  - i=N_IN-1 -> DRAIN.
- DRAIN (1 cycle): accumulate the final product.
- LUT (1 cycle):
  - s = acc >>> SHIFT.
  - Saturate s to [-2^(LUT_AW-1), 2^(LUT_AW-1)-1].
  - lut_addr = s + 2^(LUT_AW-1), i.e. MSB inverted.
- WRITE (1 cycle):
  - out_we=1, out_addr=neuron, out_data=lut_q.
  - If the latched argmax_en=1 and (neuron==0 or lut_q > digit_val, unsigned strict): digit<=neuron, digit_val<=lut_q. Ties keep the lower index.
  - Clear the accumulator.
  - neuron<N_OUT-1 -> neuron++, MAC.
  - Otherwise -> DONE.
- DONE (1 cycle): done=1, busy=1, then IDLE.
- Latency: N_OUT*(N_IN+3) cycles from the start-accepting edge to the DONE state.
- digit and digit_val hold until the next accepted start with argmax_en=1; in hidden mode they are untouched.
- start while busy is ignored; a new start is accepted the cycle after DONE.
- abort in any state: next state IDLE.
  - out_we is forced 0 in the abort cycle; no done pulse.
  - Output RAM words already written remain; digit and digit_val are undefined-but-stable (hold their current values).
- abort and start together in IDLE: abort wins, no start.
- Reset mid-operation: immediate return to the reset values; no partial write completes.
- out_we is high only in WRITE.

Decomposition:
- Package snn_pkg:
  - state enum snn_layer_state_t
  - function for LUT-address saturation/offset, parametrised via localparams
  - default constants for the SNN geometry: 784/32/10, DW=8, ACC_W=26, SHIFT=7, LUT_AW=11
- One sub-module, snn_mac:
  - signed DW x unsigned DW multiply into an ACC_W accumulator
  - clr and en inputs, async active-low reset
  - reused by the other layer instances

Test Plan:
- N_IN=4, N_OUT=3, SHIFT=0, identity-offset LUT model, inputs {1,1,1,1}, weights all 1:
  - each neuron acc=4, lut_addr=1028
  - out_we pulses 3 times at addrs 0,1,2
  - done exactly 21 cycles after start
- Saturation: inputs 255, weights 127, N_IN=784, SHIFT=7:
  - lut_addr=2047
  - with weights -128: lut_addr=0
- Argmax with LUT outputs per neuron {10,40,40}, argmax_en=1:
  - digit=1, digit_val=40 (tie keeps the lower index)
  - rerun with argmax_en=0: digit and digit_val unchanged
- Abort after 2 neuron writes:
  - busy falls next cycle, no done pulse, no third write
  - next start completes normally
- start pulsed mid-run is ignored; start and abort together in IDLE leave busy=0.
- Assert rst_n=0 during MAC of neuron 1:
  - all outputs return to 0 asynchronously
  - a fresh run produces the same results as the first scenario

Source files
------------

// File: rtl/snn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snn_pkg                                                                    |
// | Shared SNN layer types, default geometry and LUT addressing helper.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package snn_pkg;

    localparam int C_N_IN      = 784;
    localparam int C_N_OUT     = 32;
    localparam int C_N_CLASSES = 10;
    localparam int C_DW        = 8;
    localparam int C_ACC_W     = 26;
    localparam int C_SHIFT     = 7;
    localparam int C_LUT_AW    = 11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC   = 3'd1,
        S_DRAIN = 3'd2,
        S_LUT   = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } snn_layer_state_t;

    // Clamp the scaled sum to the signed LUT range, then offset to an unsigned index.
    function automatic logic [31:0] lut_sat_offset(input logic signed [63:0] s,
                                                   input int unsigned     aw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] c;
        hi = (64'sd1 <<< (aw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (aw - 1));
        if (s > hi)
            c = hi;
        else if (s < lo)
            c = lo;
        else
            c = s;
        return 32'(c + (64'sd1 <<< (aw - 1)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/snn_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snn_mac                                                                    |
// | Unsigned activation x signed weight multiply-accumulate with clear/enable.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module snn_mac
    import snn_pkg::*;
#(
    parameter int DW    = C_DW,
    parameter int ACC_W = C_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic [DW-1:0]           a,
    input  logic [DW-1:0]           b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [DW:0]     w_a;
    logic signed [DW-1:0]   w_b;
    logic signed [2*DW:0]   w_prod;
    logic signed [ACC_W-1:0] r_acc;

    assign w_a    = {1'b0, a};
    assign w_b    = b;
    assign w_prod = (2*DW+1)'(w_a) * (2*DW+1)'(w_b);

    // Clear has priority so a new neuron never inherits a stray product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_acc <= '0;
        else if (clr)
            r_acc <= '0;
        else if (en)
            r_acc <= r_acc + ACC_W'(w_prod);
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/snn_layer_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snn_layer_engine                                                           |
// | Fully-connected SNN layer sequencer: MAC, scale/saturate, LUT, write, argmax.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module snn_layer_engine
    import snn_pkg::*;
#(
    parameter  int N_IN   = C_N_IN,
    parameter  int N_OUT  = C_N_OUT,
    parameter  int DW     = C_DW,
    parameter  int ACC_W  = C_ACC_W,
    parameter  int SHIFT  = C_SHIFT,
    parameter  int LUT_AW = C_LUT_AW,
    localparam int IN_AW  = $clog2(N_IN),
    localparam int W_AW   = $clog2(N_IN * N_OUT),
    localparam int OUT_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              argmax_en,
    output logic [IN_AW-1:0]  in_addr,
    input  logic [DW-1:0]     in_q,
    output logic [W_AW-1:0]   w_addr,
    input  logic [DW-1:0]     w_q,
    output logic [LUT_AW-1:0] lut_addr,
    input  logic [DW-1:0]     lut_q,
    output logic [OUT_AW-1:0] out_addr,
    output logic [DW-1:0]     out_data,
    output logic              out_we,
    output logic              busy,
    output logic              done,
    output logic [OUT_AW-1:0] digit,
    output logic [DW-1:0]     digit_val
);

    localparam logic [IN_AW-1:0]  C_LAST_I = IN_AW'(N_IN - 1);
    localparam logic [OUT_AW-1:0] C_LAST_N = OUT_AW'(N_OUT - 1);

    snn_layer_state_t        r_state;
    logic [IN_AW-1:0]        r_i;
    logic [W_AW-1:0]         r_w_cnt;
    logic [OUT_AW-1:0]       r_neuron;
    logic                    r_amax;
    logic [OUT_AW-1:0]       r_digit;
    logic [DW-1:0]           r_digit_val;

    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_shifted;
    logic                    w_mac_en;
    logic                    w_mac_clr;
    logic                    w_win;

    // Read data lags the address by one cycle, so the first MAC cycle has nothing to add.
    assign w_mac_en  = ((r_state == S_MAC) && (r_i != '0)) || (r_state == S_DRAIN);
    assign w_mac_clr = (r_state == S_IDLE) || (r_state == S_WRITE);

    snn_mac #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_mac_clr),
        .en    (w_mac_en),
        .a     (in_q),
        .b     (w_q),
        .acc   (w_acc)
    );

    assign w_shifted = w_acc >>> SHIFT;
    assign w_win     = r_amax && ((r_neuron == '0) || (lut_q > r_digit_val));

    assign in_addr   = r_i;
    assign w_addr    = r_w_cnt;
    assign lut_addr  = (r_state == S_LUT) ? LUT_AW'(lut_sat_offset(64'(w_shifted), LUT_AW)) : '0;
    assign out_addr  = r_neuron;
    assign out_data  = (r_state == S_WRITE) ? lut_q : '0;
    assign out_we    = (r_state == S_WRITE) && !abort;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE) && !abort;
    assign digit     = r_digit;
    assign digit_val = r_digit_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_i         <= '0;
            r_w_cnt     <= '0;
            r_neuron    <= '0;
            r_amax      <= 1'b0;
            r_digit     <= '0;
            r_digit_val <= '0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_i     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_MAC;
                        r_i      <= '0;
                        r_w_cnt  <= '0;
                        r_neuron <= '0;
                        r_amax   <= argmax_en;
                        if (argmax_en) begin
                            r_digit     <= '0;
                            r_digit_val <= '0;
                        end
                    end
                end
                S_MAC: begin
                    // Weight address runs on across neurons, giving neuron*N_IN+i for free.
                    r_w_cnt <= r_w_cnt + W_AW'(1);
                    if (r_i == C_LAST_I) begin
                        r_i     <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_i <= r_i + IN_AW'(1);
                    end
                end
                S_DRAIN: r_state <= S_LUT;
                S_LUT:   r_state <= S_WRITE;
                S_WRITE: begin
                    if (w_win) begin
                        r_digit     <= r_neuron;
                        r_digit_val <= lut_q;
                    end
                    if (r_neuron == C_LAST_N) begin
                        r_state <= S_DONE;
                    end else begin
                        r_neuron <= r_neuron + OUT_AW'(1);
                        r_state  <= S_MAC;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_snn_layer_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_snn_layer_engine                                                        |
// | Directed and randomized checks of the layer engine against a sum model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_snn_layer_engine;

    localparam int T_IN    = 4;
    localparam int T_OUT   = 3;
    localparam int T_SHIFT = 0;
    localparam int S_NIN   = 784;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, abort, argmax_en;
    logic [1:0]  in_addr;
    logic [3:0]  w_addr;
    logic [10:0] lut_addr;
    logic [1:0]  out_addr, digit;
    logic [7:0]  in_q, w_q, lut_q, out_data, digit_val;
    logic        out_we, busy, done;

    logic        start_s;
    logic [9:0]  in_addr_s, w_addr_s;
    logic [10:0] lut_addr_s;
    logic [0:0]  out_addr_s, digit_s;
    logic [7:0]  in_q_s, w_q_s, lut_q_s, out_data_s, digit_val_s;
    logic        out_we_s, busy_s, done_s;

    logic [7:0]  in_mem  [T_IN];
    logic [7:0]  w_mem   [16];
    logic [7:0]  lut_mem [2048];

    int          wr_addr_q[$], wr_data_q[$], wr_lut_q[$];
    int          done_cnt;
    logic [10:0] lut_prev, lut_prev_s;
    int          sat_lut;
    int          n_tests = 0;
    int          n_fail  = 0;

    snn_layer_engine #(.N_IN(T_IN), .N_OUT(T_OUT), .DW(8), .ACC_W(26),
                       .SHIFT(T_SHIFT), .LUT_AW(11)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .argmax_en(argmax_en),
        .in_addr(in_addr), .in_q(in_q), .w_addr(w_addr), .w_q(w_q),
        .lut_addr(lut_addr), .lut_q(lut_q), .out_addr(out_addr), .out_data(out_data),
        .out_we(out_we), .busy(busy), .done(done), .digit(digit), .digit_val(digit_val)
    );

    snn_layer_engine #(.N_IN(S_NIN), .N_OUT(1), .DW(8), .ACC_W(26),
                       .SHIFT(7), .LUT_AW(11)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s), .abort(1'b0), .argmax_en(1'b0),
        .in_addr(in_addr_s), .in_q(in_q_s), .w_addr(w_addr_s), .w_q(w_q_s),
        .lut_addr(lut_addr_s), .lut_q(lut_q_s), .out_addr(out_addr_s), .out_data(out_data_s),
        .out_we(out_we_s), .busy(busy_s), .done(done_s), .digit(digit_s), .digit_val(digit_val_s)
    );

    always @(posedge clk) begin
        in_q  <= in_mem[in_addr];
        w_q   <= w_mem[w_addr];
        lut_q <= lut_mem[lut_addr];
    end

    // The LUT address is only meaningful the cycle before each write.
    always @(negedge clk) begin
        if (out_we) begin
            wr_addr_q.push_back(int'(out_addr));
            wr_data_q.push_back(int'(out_data));
            wr_lut_q.push_back(int'(lut_prev));
        end
        if (done) done_cnt++;
        if (out_we_s) sat_lut = int'(lut_prev_s);
        lut_prev   = lut_addr;
        lut_prev_s = lut_addr_s;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int model_addr(int n);
        longint acc = 0;
        longint s;
        for (int i = 0; i < T_IN; i++)
            acc += longint'(in_mem[i]) * longint'($signed(w_mem[n*T_IN + i]));
        s = acc >>> T_SHIFT;
        if (s > 1023) s = 1023;
        else if (s < -1024) s = -1024;
        return int'(s) + 1024;
    endfunction

    task automatic model_argmax(output int d, output int v);
        d = 0;
        v = 0;
        for (int n = 0; n < T_OUT; n++) begin
            int val;
            val = int'(lut_mem[model_addr(n)]);
            if (n == 0 || val > v) begin
                d = n;
                v = val;
            end
        end
    endtask

    task automatic run_layer(input string tag, input bit amax, input int pulse_at, output int cycles);
        wr_addr_q.delete(); wr_data_q.delete(); wr_lut_q.delete();
        done_cnt = 0;
        start = 1'b1; argmax_en = amax;
        tick();
        start = 1'b0; argmax_en = ~amax;
        cycles = 0;
        while (!done && cycles < 200) begin
            start = (cycles == pulse_at);
            tick();
            cycles++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, done, 1);
        tick();
        chk({tag, "_done_1cyc"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic verify_run(input string tag, input int cycles);
        chk({tag, "_latency"}, cycles, T_OUT * (T_IN + 3));
        chk({tag, "_nwrites"}, wr_addr_q.size(), T_OUT);
        chk({tag, "_ndone"}, done_cnt, 1);
        for (int n = 0; n < T_OUT && n < wr_addr_q.size(); n++) begin
            chk($sformatf("%s_addr%0d", tag, n), wr_addr_q[n], n);
            chk($sformatf("%s_lut%0d", tag, n), wr_lut_q[n], model_addr(n));
            chk($sformatf("%s_data%0d", tag, n), wr_data_q[n], int'(lut_mem[model_addr(n)]));
        end
    endtask

    task automatic setup_a();
        for (int i = 0; i < T_IN; i++) in_mem[i] = 8'd1;
        for (int i = 0; i < 16; i++) w_mem[i] = 8'd1;
        for (int a = 0; a < 2048; a++) lut_mem[a] = 8'(a);
    endtask

    task automatic run_sat(input string tag, input logic [7:0] wv, input int exp_lut);
        int cyc;
        in_q_s = 8'd255; w_q_s = wv; sat_lut = -1;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        cyc = 0;
        while (!done_s && cyc < 2000) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, S_NIN + 3);
        chk({tag, "_lut"}, sat_lut, exp_lut);
        tick();
    endtask

    initial begin
        int cyc, ed, ev, prev_d, prev_v, waited;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; argmax_en = 1'b0;
        start_s = 1'b0; in_q_s = 8'd0; w_q_s = 8'd0; lut_q_s = 8'd0;
        setup_a();
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", out_we, 0);
        chk("rst_in_addr", in_addr, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_lut_addr", lut_addr, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_digit", digit, 0);
        chk("rst_digit_val", digit_val, 0);
        rst_n = 1'b1;
        tick();

        run_layer("A", 1'b0, -1, cyc);
        verify_run("A", cyc);
        chk("A_lut_abs", (wr_lut_q.size() > 0) ? wr_lut_q[0] : -1, 1028);

        run_layer("pulse", 1'b0, 5, cyc);
        verify_run("pulse", cyc);

        for (int n = 0; n < T_OUT; n++)
            for (int i = 0; i < T_IN; i++) w_mem[n*T_IN + i] = 8'(n + 1);
        lut_mem[1028] = 8'd10; lut_mem[1032] = 8'd40; lut_mem[1036] = 8'd40;
        run_layer("amax", 1'b1, -1, cyc);
        verify_run("amax", cyc);
        chk("amax_digit", digit, 1);
        chk("amax_val", digit_val, 40);
        lut_mem[1036] = 8'd200;
        run_layer("hidden", 1'b0, -1, cyc);
        verify_run("hidden", cyc);
        chk("hidden_digit", digit, 1);
        chk("hidden_val", digit_val, 40);

        setup_a();
        start = 1'b1; argmax_en = 1'b0;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("mid_w_addr", w_addr, 5);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_w_addr", w_addr, 0);
        chk("arst_in_addr", in_addr, 0);
        chk("arst_digit", digit, 0);
        chk("arst_digit_val", digit_val, 0);
        chk("arst_we", out_we, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_layer("postrst", 1'b0, -1, cyc);
        verify_run("postrst", cyc);

        wr_addr_q.delete(); wr_data_q.delete(); wr_lut_q.delete();
        done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        waited = 0;
        while (wr_addr_q.size() < 2 && waited < 100) begin
            tick();
            waited++;
        end
        chk("abort_two_writes", wr_addr_q.size(), 2);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        repeat (40) tick();
        chk("abort_nwrites", wr_addr_q.size(), 2);
        chk("abort_no_done", done_cnt, 0);
        run_layer("after_abort", 1'b0, -1, cyc);
        verify_run("after_abort", cyc);

        start = 1'b1; abort = 1'b1;
        tick();
        chk("start_abort_busy", busy, 0);
        tick();
        chk("start_abort_busy2", busy, 0);
        start = 1'b0; abort = 1'b0;
        tick();

        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < T_IN; i++)
                in_mem[i] = 8'((it % 2 == 1) ? $urandom_range(0, 15) : $urandom_range(0, 255));
            for (int i = 0; i < T_IN*T_OUT; i++) w_mem[i] = 8'($urandom);
            for (int a = 0; a < 2048; a++) lut_mem[a] = 8'($urandom);
            prev_d = int'(digit); prev_v = int'(digit_val);
            run_layer($sformatf("rnd%0d", it), (it != 2), -1, cyc);
            verify_run($sformatf("rnd%0d", it), cyc);
            if (it != 2) begin
                model_argmax(ed, ev);
            end else begin
                ed = prev_d; ev = prev_v;
            end
            chk($sformatf("rnd%0d_digit", it), digit, ed);
            chk($sformatf("rnd%0d_val", it), digit_val, ev);
        end

        run_sat("sat_hi", 8'd127, 2047);
        run_sat("sat_lo", 8'h80, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
